pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the ID/EX stage register and its neighbours.
- Detects load-use hazards between the instruction in ID and a load held in the ID/EX register.
- Freezes the pipe while a multi-cycle data-memory access is outstanding.
- Squashes wrong-path instructions after a taken branch or jump.
- Drives the hold, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers, and keeps saturating stall and flush counters.

Parameters:
REG_W, 3, register-index width (matches reg1/reg2/regD fields)
FLUSH_CYCLES, 2, total cycles of ID/EX bubbling per redirect, legal range 1..15
ZERO_REG, 1, if 1 then register index 0 is hardwired and never causes a hazard
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_err asserts, legal range 1..255
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_reg1  in  REG_W  source register 1 of the instruction in ID
id_reg2  in  REG_W  source register 2 of the instruction in ID
id_uses_reg1  in  1  ID instruction reads id_reg1
id_uses_reg2  in  1  ID instruction reads id_reg2
ex_read_mem  in  1  read_mem control currently held in ID/EX
ex_regD  in  REG_W  destination register held in ID/EX
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
mem_req  in  1  MEM stage has an access in flight
mem_ready  in  1  data memory completes the access this cycle
cnt_clr  in  1  synchronous clear of both counters
pc_hold  out  1  PC keeps its value
if_id_hold  out  1  IF/ID keeps its contents
if_id_flush  out  1  IF/ID loads a NOP
id_ex_hold  out  1  ID/EX keeps its contents
id_ex_bubble  out  1  ID/EX loads zeros into alu_op, write_mem, write_reg and read_mem
ex_mem_hold  out  1  EX/MEM keeps its contents
mem_timeout_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles lost to stalls
flush_cnt  out  CNT_W  redirect events

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: state = RUN, flush counter = 0, wait counter = 0, mem_timeout_err = 0, stall_cnt = 0, flush_cnt = 0.
- Control outputs are combinational from the registered state and the current inputs (zero latency). Under reset, all control outputs are 0.
- Load-use hazard (lu) = ex_read_mem AND ((id_uses_reg1 AND id_reg1 == ex_regD) OR (id_uses_reg2 AND id_reg2 == ex_regD)).
  - lu is forced to 0 when ZERO_REG = 1 and ex_regD == 0.
- States: RUN, FLUSH, MEM_WAIT.
- RUN, evaluated in priority order:
  1. ex_redirect = 1:
     - Outputs: if_id_flush = 1, id_ex_bubble = 1.
     - flush_cnt increments.
     - If FLUSH_CYCLES > 1: go to FLUSH with the flush counter loaded to FLUSH_CYCLES - 1.
     - Any concurrent lu is ignored.
  2. mem_req = 1 AND mem_ready = 0:
     - Outputs: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold all = 1.
     - Go to MEM_WAIT with the wait counter = 1.
     - stall_cnt increments.
  3. lu = 1:
     - Outputs: pc_hold = 1, if_id_hold = 1, id_ex_bubble = 1 for exactly this cycle.
     - stall_cnt increments.
     - Stay in RUN. The bubble clears ex_read_mem on the next cycle, so the hazard resolves without extra state.
  4. Otherwise: all control outputs = 0.
- FLUSH:
  - Outputs: id_ex_bubble = 1, if_id_flush = 1, all holds = 0.
  - The counter decrements each cycle. When the counter reaches 1, this is the last FLUSH cycle and the next state is RUN.
  - A new ex_redirect in FLUSH reloads the counter to FLUSH_CYCLES - 1 and increments flush_cnt.
  - mem_req in FLUSH: the freeze takes priority. Go to MEM_WAIT and keep the remaining flush count, then return to FLUSH after release.
- MEM_WAIT:
  - All four holds = 1 every cycle that mem_ready = 0. stall_cnt increments on each such cycle.
  - mem_ready = 1: all holds = 0 in that same cycle. Return to RUN, or to FLUSH if a flush count remains.
  - ex_redirect is ignored in MEM_WAIT. EX is frozen, so the redirect is re-seen after release.
  - The wait counter saturates. When it reaches MEM_TIMEOUT, mem_timeout_err sets. It clears only on reset. The freeze continues regardless.
- Counters:
  - Both counters saturate at 2^CNT_W - 1.
  - cnt_clr has priority over an increment in the same cycle.
- Reset asserted mid-operation: state returns to RUN immediately and all outputs are 0 while rst_n = 0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum typedef (RUN, FLUSH, MEM_WAIT);
  - REG_W;
  - the NOP encoding used by the if_id_flush consumers.
- One natural sub-module, sat_counter (CNT_W, inc, clr, rst_n), instantiated for stall_cnt and flush_cnt.

Test Plan:
- Load-use: ex_read_mem = 1, ex_regD = 3, id_reg2 = 3, id_uses_reg2 = 1 -> one cycle of pc_hold = if_id_hold = id_ex_bubble = 1, then all 0; stall_cnt = 1.
- Zero register: same as the load-use case with ex_regD = 0 and id_reg1 = 0, id_uses_reg1 = 1 -> no stall. With ZERO_REG = 0 -> a one-cycle stall.
- Redirect: ex_redirect pulsed 1 cycle with FLUSH_CYCLES = 2 -> if_id_flush and id_ex_bubble high for 2 cycles; flush_cnt = 1. Back-to-back redirects -> bubble extends and flush_cnt = 2.
- Memory wait: mem_req = 1 with mem_ready low for 4 cycles -> all holds high for 4 cycles and low in the mem_ready cycle; stall_cnt = 4.
- Timeout: MEM_TIMEOUT = 8, mem_ready held low for 10 cycles -> mem_timeout_err rises on the 8th wait cycle and stays high after mem_ready; it clears only on rst_n low.
- Priority and reset: ex_redirect together with lu -> flush only, stall_cnt unchanged. rst_n low during MEM_WAIT -> outputs 0 asynchronously, and RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    localparam int REG_W = 3;

    // Instruction word that IF/ID consumers substitute when if_id_flush is asserted.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX sequencing controller: load-use stalls, memory freezes and redirect squashing,
// with saturating stall/flush counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int ZERO_REG     = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_reg1_i,
    input  logic [REG_W-1:0] id_reg2_i,
    input  logic             id_uses_reg1_i,
    input  logic             id_uses_reg2_i,
    input  logic             ex_read_mem_i,
    input  logic [REG_W-1:0] ex_regD_i,
    input  logic             ex_redirect_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             cnt_clr_i,
    output logic             pc_hold_o,
    output logic             if_id_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_hold_o,
    output logic             id_ex_bubble_o,
    output logic             ex_mem_hold_o,
    output logic             mem_timeout_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    import pipe_ctrl_pkg::*;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT      = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [3:0] flush_q, flush_d;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;
    logic       lu_s, mem_stall_s, stall_inc_s, flush_inc_s;
    logic       pc_hold_s, if_id_hold_s, if_id_flush_s, id_ex_hold_s, id_ex_bubble_s, ex_mem_hold_s;

    assign mem_stall_s = mem_req_i && !mem_ready_i;
    assign lu_s = ex_read_mem_i
                  && ((id_uses_reg1_i && (id_reg1_i == ex_regD_i))
                      || (id_uses_reg2_i && (id_reg2_i == ex_regD_i)))
                  && !((ZERO_REG != 0) && (ex_regD_i == {REG_W{1'b0}}));

    // State, flush-remaining, wait and timeout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            flush_q <= 4'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    // Next state; the remaining flush count survives a freeze so FLUSH resumes afterwards.
    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        wait_d      = 8'd0;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_redirect_i) begin
                    flush_inc_s = 1'b1;
                    flush_d     = FLUSH_RELOAD;
                    state_d     = (FLUSH_RELOAD != 4'd0) ? FLUSH : RUN;
                end else if (mem_stall_s) begin
                    stall_inc_s = 1'b1;
                    wait_d      = 8'd1;
                    state_d     = MEM_WAIT;
                end else if (lu_s) begin
                    stall_inc_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (mem_stall_s) begin
                    stall_inc_s = 1'b1;
                    wait_d      = 8'd1;
                    state_d     = MEM_WAIT;
                end else if (ex_redirect_i) begin
                    flush_inc_s = 1'b1;
                    flush_d     = FLUSH_RELOAD;
                    state_d     = (FLUSH_RELOAD != 4'd0) ? FLUSH : RUN;
                end else if (flush_q <= 4'd1) begin
                    flush_d = 4'd0;
                    state_d = RUN;
                end else begin
                    flush_d = flush_q - 4'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready_i) begin
                    state_d = (flush_q != 4'd0) ? FLUSH : RUN;
                end else begin
                    stall_inc_s = 1'b1;
                    wait_d      = (wait_q >= TIMEOUT) ? wait_q : wait_q + 8'd1;
                end
            end
            default: begin
                state_d = RUN;
                flush_d = 4'd0;
            end
        endcase
        err_d = err_q || (wait_d == TIMEOUT);
    end

    // Control outputs from current state and inputs.
    always_comb begin
        pc_hold_s      = 1'b0;
        if_id_hold_s   = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_hold_s   = 1'b0;
        id_ex_bubble_s = 1'b0;
        ex_mem_hold_s  = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_redirect_i) begin
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end else if (mem_stall_s) begin
                    pc_hold_s     = 1'b1;
                    if_id_hold_s  = 1'b1;
                    id_ex_hold_s  = 1'b1;
                    ex_mem_hold_s = 1'b1;
                end else if (lu_s) begin
                    pc_hold_s      = 1'b1;
                    if_id_hold_s   = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end else begin
                    pc_hold_s = 1'b0;
                end
            end
            FLUSH: begin
                if (mem_stall_s) begin
                    pc_hold_s     = 1'b1;
                    if_id_hold_s  = 1'b1;
                    id_ex_hold_s  = 1'b1;
                    ex_mem_hold_s = 1'b1;
                end else begin
                    if_id_flush_s  = 1'b1;
                    id_ex_bubble_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready_i) begin
                    pc_hold_s     = 1'b1;
                    if_id_hold_s  = 1'b1;
                    id_ex_hold_s  = 1'b1;
                    ex_mem_hold_s = 1'b1;
                end else begin
                    pc_hold_s = 1'b0;
                end
            end
            default: begin
                pc_hold_s = 1'b0;
            end
        endcase
    end

    // Gate with rst_n so controls drop asynchronously while reset is held.
    assign pc_hold_o         = rst_n && pc_hold_s;
    assign if_id_hold_o      = rst_n && if_id_hold_s;
    assign if_id_flush_o     = rst_n && if_id_flush_s;
    assign id_ex_hold_o      = rst_n && id_ex_hold_s;
    assign id_ex_bubble_o    = rst_n && id_ex_bubble_s;
    assign ex_mem_hold_o     = rst_n && ex_mem_hold_s;
    assign mem_timeout_err_o = err_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_i),
        .inc_i (stall_inc_s),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_i),
        .inc_i (flush_inc_s),
        .cnt_o (flush_cnt_o)
    );

endmodule
